// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and defaults for the bit-serial adder controller.
// Optional feature macro used by serial_add_ctrl: SERIAL_ADD_OVF_EN.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/halfadder.sv
// halfadder: one-bit half adder, sum and carry of two input bits.
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Pure combinational half-add.
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

// File: rtl/serial_add_slice.sv
// serial_add_slice: full-adder bit slice built from two half adders and an OR.
// The two carries can never both be high, so OR merges them into the carry out.
module serial_add_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    halfadder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // Merge the two partial carries.
    always_comb begin
        cout = c0 | c1;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, one operand bit per clock, LSB first.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one bit per edge through the shared slice; WIDTH edges in total
// DONE  | sum/cout valid, done high for this single cycle, then back to IDLE
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the low WIDTH-1 result bits; the final bit joins them on the last edge.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-2:0] res_shift;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             sbit;
    logic             carry_nxt;

    serial_add_slice u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (sbit),
        .cout (carry_nxt)
    );

    // Next result register value: shift right, new sum bit enters at the top.
    always_comb begin
        res_shift = res_sh;
        for (int i = 0; i < WIDTH - 2; i++) begin
            res_shift[i] = res_sh[i+1];
        end
        res_shift[WIDTH-2] = sbit;
    end

    // Controller FSM with operand/result shift registers, carry flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_shift;
                    carry  <= carry_nxt;
                    if (cnt == CNT_LAST) begin
                        // Counter is left at its last value rather than wrapping.
                        sum   <= {sbit, res_sh};
                        cout  <= carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB here.
                        ovf   <= carry ^ carry_nxt;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl at WIDTH=8.
// Builds with or without SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Present operands with start for one edge; returns at the negedge after acceptance.
    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = ~bv;
    endtask

    // Counts negedges until done is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
                     busy, done, sum, cout);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b, required 0", ovf);
        end
`endif
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int busy_cycles;
        int early_done;
        int sum_moved;
        busy_cycles = 0;
        early_done = 0;
        sum_moved = 0;
        launch(8'h3C, 8'h05);
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_cycles++;
            if (done !== 1'b0) early_done++;
            if (sum !== 8'h00) sum_moved++;
            @(negedge clk);
        end
        checks++;
        if (busy_cycles != 8 || early_done != 0) begin
            errors++;
            $display("FAIL basic_busy: busy cycles=%0d early done=%0d, required 8 and 0",
                     busy_cycles, early_done);
        end
        checks++;
        if (sum_moved != 0) begin
            errors++;
            $display("FAIL basic_sum_held: sum changed in %0d RUN cycles, required 0", sum_moved);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b, required 1 0", done, busy);
        end
        checks++;
        if (sum !== 8'h41 || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: sum=%h cout=%b, required 41 0", sum, cout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_carry_ovf();
        logic [7:0] va   [5] = '{8'hFF, 8'h7F, 8'h80, 8'hA5, 8'hC8};
        logic [7:0] vb   [5] = '{8'h01, 8'h01, 8'h80, 8'h5A, 8'h64};
        logic [7:0] vs   [5] = '{8'h00, 8'h80, 8'h00, 8'hFF, 8'h2C};
        logic       vc   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       vo   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i]);
            wait_done(lat);
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL carry_latency[%0d]: %0d cycles, required 8", i, lat);
            end
            checks++;
            if (sum !== vs[i] || cout !== vc[i]) begin
                errors++;
                $display("FAIL carry_result[%0d]: %h+%h sum=%h cout=%b, required %h %b",
                         i, va[i], vb[i], sum, cout, vs[i], vc[i]);
            end
`ifdef SERIAL_ADD_OVF_EN
            checks++;
            if (ovf !== vo[i]) begin
                errors++;
                $display("FAIL carry_ovf[%0d]: got %b, required %b", i, ovf, vo[i]);
            end
`else
            if (vo[i] === 1'bx) $display("unexpected table entry %0d", i);
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        launch(8'h10, 8'h20);
        a = 8'h00;
        b = 8'h00;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        a = 8'hFF;
        b = 8'hFF;
        wait_done(lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL ignore_latency: done %0d cycles after E3, required 5", lat);
        end
        checks++;
        if (sum !== 8'h30 || cout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: sum=%h cout=%b, required 30 0", sum, cout);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_rerun: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int stray_done;
        stray_done = 0;
        launch(8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_running: busy=%b before reset, required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
                     busy, done, sum, cout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray_done++;
        end
        checks++;
        if (stray_done != 0) begin
            errors++;
            $display("FAIL midreset_no_done: %0d cycles with activity, required 0", stray_done);
        end
        launch(8'h01, 8'h02);
        wait_done(lat);
        checks++;
        if (lat != 8 || sum !== 8'h03 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: lat=%0d sum=%h cout=%b, required 8 03 0", lat, sum, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int pulses [$];
        int bad_sum;
        bad_sum = 0;
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses.push_back(n);
                if (sum !== 8'h46 || cout !== 1'b0 || busy !== 1'b0) bad_sum++;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d done pulses, required 3", pulses.size());
        end else begin
            checks++;
            if (pulses[0] != 9 || pulses[1] != 19 || pulses[2] != 29) begin
                errors++;
                $display("FAIL b2b_spacing: pulses at %0d %0d %0d, required 9 19 29",
                         pulses[0], pulses[1], pulses[2]);
            end
        end
        checks++;
        if (bad_sum != 0) begin
            errors++;
            $display("FAIL b2b_result: %0d pulses with wrong sum/cout/busy, required 0", bad_sum);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ovf();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder controller. It sequences a single shared bit-slice built from two existing `halfadder` instances plus an OR gate, processing one operand bit per clock, LSB first.
- It accepts a start pulse, runs WIDTH bit-cycles, then presents the registered sum and carry-out with a one-cycle done pulse.
- It is the area-minimal alternative to a parallel ripple adder, for slow configuration and arithmetic paths.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 2 to 64.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to add; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when sum and cout are valid.
- sum  output  WIDTH  result, held until the next completion.
- cout  output  1  carry out of the MSB, held with sum.

Interface decision: one clock `clk`; reset `rst_n` is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset takes effect immediately, even mid-RUN; the partial result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: load a and b into shift registers, clear the carry flop, set cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, at each edge:
  - Bit slice: ha0(a_sh[0], b_sh[0]) gives s0 and c0. ha1(s0, carry) gives sbit and c1. Next carry = c0 | c1.
  - sbit is shifted into the MSB of the result shift register, which shifts right.
  - a_sh and b_sh shift right.
  - cnt increments.
  - On the edge where cnt == WIDTH-1: copy the result to sum, copy next carry to cout, go to DONE.
  - start is ignored throughout RUN.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge goes to IDLE unconditionally; start in DONE is ignored.
- Latency:
  - Start accepted at edge E0; done is high between edges E(WIDTH) and E(WIDTH+1).
  - Throughput is one add per WIDTH+2 cycles.
- Arithmetic: unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b.
- Operand stability: a and b may change freely after the accepting edge.
- Outputs: sum and cout change only on the DONE-entry edge or on reset.
- Counter width is $clog2(WIDTH); it never wraps mid-operation.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- When defined:
  - Adds output port `ovf` (1 bit).
  - ovf = two's-complement signed overflow, computed as carry into MSB XOR carry out of MSB.
  - The carry into the MSB is the carry flop value at the last RUN edge.
  - ovf is registered with sum, reset to 0, and held with sum.
- When undefined: no ovf port and no extra logic; all other behaviour is identical.

Decomposition:
- Package `serial_add_pkg` holds:
  - State enum typedef {IDLE, RUN, DONE}, 2 bits.
  - Localparam for the default width.
- Sub-module: the existing `halfadder`, instantiated twice inside a small `serial_add_slice` (full-adder bit slice).
- Controller FSM, shift registers and counter stay in `serial_add_ctrl`.

Test Plan (WIDTH=8):
- Reset, then a=0x3C, b=0x05, start pulse at E0 -> busy high E1..E8; done pulse after E8; sum=0x41, cout=0; done pulse is exactly one cycle wide.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; with SERIAL_ADD_OVF_EN, ovf=0.
- a=0x7F, b=0x01 (with macro) -> sum=0x80, cout=0, ovf=1. a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- Start with a=0x10, b=0x20; at E3 pulse start with a=0xAA, b=0x55 and change a/b -> second start ignored; result is sum=0x30, cout=0.
- Start 0xFF+0xFF; assert rst_n=0 mid-cycle after E4 -> busy, done, sum, cout go to 0 immediately without a clock edge; no done follows. After release, 0x01+0x02 -> sum=0x03.
- Back-to-back: hold start high continuously with 0x12+0x34 -> done every 10 cycles, sum=0x46; start is ignored in RUN and DONE.
